// File: rtl/arb_pkg.sv
// Shared definitions for the seven-requester tri-state bus arbiter.
package arb_pkg;

    localparam int unsigned NREQ   = 7;
    localparam int unsigned ID_W   = 3;
    localparam int unsigned TCNT_W = 8;

    localparam logic [ID_W-1:0] ID_NONE = 3'd0;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GRANT = 2'b01,
        TURN  = 2'b10
    } state_t;

    // Decode a priority index (0 = none) into a one-hot grant vector.
    function automatic logic [NREQ:1] id_to_onehot(input logic [ID_W-1:0] id);
        logic [NREQ:1] oh;
        oh = '0;
        for (int i = 1; i <= int'(NREQ); i++) begin
            if (id == ID_W'(i)) begin
                oh[i] = 1'b1;
            end
        end
        return oh;
    endfunction

endpackage

// File: rtl/bus_arbiter7_arb.sv
// Arbitration stage: applies the preemption mask, then picks a winner through priority7.
module bus_arbiter7_arb
    import arb_pkg::*;
(
    input  logic [NREQ:1]   req,
    input  logic [NREQ:1]   mask,
    output logic [NREQ:1]   win_c,
    output logic [ID_W-1:0] win_id_c
);

    logic [NREQ:1] masked;
    logic [NREQ:1] arb_in;

    // A masked requester still wins when nobody else is asking.
    always_comb begin
        masked = req & ~mask;
        arb_in = (masked != '0) ? masked : req;
    end

    priority7 u_enc (
        .req (arb_in),
        .id  (win_id_c)
    );

    always_comb begin
        win_c = id_to_onehot(win_id_c);
    end

endmodule

// File: rtl/priority7.sv
// Fixed-priority encoder: index of the lowest set request bit, 0 when none.
module priority7 (
    input  logic [7:1] req,
    output logic [2:0] id
);

    // Scan from the lowest priority up so the highest-priority hit is written last.
    always_comb begin
        id = 3'd0;
        for (int i = 7; i >= 1; i--) begin
            if (req[i]) begin
                id = 3'(i);
            end
        end
    end

endmodule

// File: rtl/bus_arbiter7.sv
// Seven-way tri-state bus arbiter: fixed priority, tenure-limited grants and a
// one-cycle turnaround between drivers.
module bus_arbiter7
    import arb_pkg::*;
#(
    parameter int unsigned TENURE = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ:1]   req,
    output logic [NREQ:1]   gnt,
    output logic [ID_W-1:0] gnt_id,
    output logic            busy
);

    localparam logic [TCNT_W-1:0] TEN_LAST = TCNT_W'(TENURE - 1);
    localparam logic [TCNT_W-1:0] TEN_MAX  = TCNT_W'(TENURE);

    state_t            state, state_n;
    logic [NREQ:1]     gnt_n;
    logic [ID_W-1:0]   gnt_id_n;
    logic              busy_n;
    logic [TCNT_W-1:0] tcnt, tcnt_n;
    logic [NREQ:1]     mask, mask_n;
    logic [NREQ:1]     win;
    logic [ID_W-1:0]   win_id;

    bus_arbiter7_arb u_arb (
        .req      (req),
        .mask     (mask),
        .win_c    (win),
        .win_id_c (win_id)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            gnt    <= '0;
            gnt_id <= ID_NONE;
            busy   <= 1'b0;
            tcnt   <= '0;
            mask   <= '0;
        end else begin
            state  <= state_n;
            gnt    <= gnt_n;
            gnt_id <= gnt_id_n;
            busy   <= busy_n;
            tcnt   <= tcnt_n;
            mask   <= mask_n;
        end
    end

    // Next state plus next values of the registered outputs.
    always_comb begin
        state_n  = state;
        gnt_n    = gnt;
        gnt_id_n = gnt_id;
        tcnt_n   = tcnt;
        mask_n   = mask;

        if ((req & mask) == '0) begin
            mask_n = '0;
        end

        case (state)
            IDLE, TURN: begin
                state_n  = IDLE;
                gnt_n    = '0;
                gnt_id_n = ID_NONE;
                tcnt_n   = '0;
                if (win_id != ID_NONE) begin
                    state_n  = GRANT;
                    gnt_n    = win;
                    gnt_id_n = win_id;
                    mask_n   = '0;
                end
            end
            GRANT: begin
                if (tcnt != TEN_MAX) begin
                    tcnt_n = tcnt + TCNT_W'(1);
                end
                // Release wins over tenure expiry, so no mask in that case.
                if ((req & gnt) == '0) begin
                    state_n  = TURN;
                    gnt_n    = '0;
                    gnt_id_n = ID_NONE;
                end else if (tcnt == TEN_LAST && (req & ~gnt) != '0) begin
                    state_n  = TURN;
                    mask_n   = gnt;
                    gnt_n    = '0;
                    gnt_id_n = ID_NONE;
                end
            end
            default: begin
                state_n  = IDLE;
                gnt_n    = '0;
                gnt_id_n = ID_NONE;
                tcnt_n   = '0;
                mask_n   = '0;
            end
        endcase

        busy_n = (state_n == GRANT);
    end

endmodule

// File: tb/tb_bus_arbiter7.sv
// Randomized and directed bench for bus_arbiter7 at TENURE = 4, 2 and 1.
module tb_bus_arbiter7;

    localparam int NI = 3;

    typedef struct packed {
        int holder;
        int held;
        int masked;
        int tenure;
    } mdl_t;

    logic       clk;
    logic       rst;
    logic [7:1] req;
    logic [7:1] gnt_w    [NI];
    logic [2:0] gnt_id_w [NI];
    logic       busy_w   [NI];

    mdl_t m [NI];
    int   n_checks;
    int   n_errors;

    localparam logic [7:1] R34 [5] = '{7'b0010010, 7'b0010010, 7'b0010010, 7'b0010000, 7'b0010000};
    localparam int         E34 [5] = '{2, 2, 2, 0, 5};
    localparam logic [7:1] R5  [8] = '{7'b0100001, 7'b0100001, 7'b0100001, 7'b0100001,
                                       7'b0100001, 7'b0100001, 7'b0000001, 7'b0000001};
    localparam int         E5  [8] = '{1, 1, 1, 1, 0, 6, 0, 1};
    localparam logic [7:1] R6A [6] = '{7'b0000101, 7'b0000101, 7'b0000101, 7'b0000101,
                                       7'b0000001, 7'b0000001};
    localparam int         E6A [6] = '{1, 1, 0, 3, 0, 1};
    localparam logic [7:1] R6B [5] = '{7'b0000101, 7'b0000101, 7'b0000101, 7'b0000001, 7'b0000001};
    localparam int         E6B [5] = '{1, 1, 0, 1, 1};

    for (genvar g = 0; g < NI; g++) begin : g_dut
        bus_arbiter7 #(.TENURE(g == 0 ? 4 : (g == 1 ? 2 : 1))) dut (
            .clk    (clk),
            .rst    (rst),
            .req    (req),
            .gnt    (gnt_w[g]),
            .gnt_id (gnt_id_w[g]),
            .busy   (busy_w[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int lowest(input logic [7:1] p);
        for (int i = 1; i <= 7; i++) begin
            if (p[i]) return i;
        end
        return 0;
    endfunction

    function automatic bit others_pending(input logic [7:1] r, input int holder);
        for (int i = 1; i <= 7; i++) begin
            if (r[i] && i != holder) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Bus ownership after one clock edge that sampled request vector r.
    function automatic mdl_t mdl_step(input mdl_t s, input logic [7:1] r);
        mdl_t       n;
        logic [7:1] p;
        int         w;
        n = s;
        if (s.holder != 0) begin
            if (!r[s.holder]) begin
                n.holder = 0;
            end else if (s.held == s.tenure && others_pending(r, s.holder)) begin
                n.masked = s.holder;
                n.holder = 0;
            end else if (s.held < 1000) begin
                n.held = s.held + 1;
            end
            if (n.masked != 0 && !r[n.masked]) n.masked = 0;
        end else begin
            p = r;
            if (s.masked != 0) p[s.masked] = 1'b0;
            if (p == '0) p = r;
            w = lowest(p);
            if (w != 0) begin
                n.holder = w;
                n.held   = 1;
                n.masked = 0;
            end else if (s.masked != 0 && !r[s.masked]) begin
                n.masked = 0;
            end
        end
        return n;
    endfunction

    task automatic compare_all();
        logic [7:1] e;
        for (int g = 0; g < NI; g++) begin
            e = '0;
            if (m[g].holder != 0) e[m[g].holder] = 1'b1;
            check($sformatf("gnt[%0d]", g), 32'(gnt_w[g]), 32'(e));
            check($sformatf("gnt_id[%0d]", g), 32'(gnt_id_w[g]), 32'(m[g].holder));
            check($sformatf("busy[%0d]", g), 32'(busy_w[g]), 32'(m[g].holder != 0));
            check($sformatf("onehot[%0d]", g), 32'($onehot0(gnt_w[g])), 32'(1));
        end
    endtask

    task automatic tick(input logic [7:1] r);
        req = r;
        @(posedge clk);
        for (int g = 0; g < NI; g++) m[g] = mdl_step(m[g], r);
        #1;
        compare_all();
    endtask

    // Asserts reset mid-cycle and expects the outputs cleared before any edge.
    task automatic do_reset();
        #3;
        rst = 1'b1;
        #1;
        for (int g = 0; g < NI; g++) begin
            check($sformatf("rst_gnt[%0d]", g), 32'(gnt_w[g]), 32'(0));
            check($sformatf("rst_id[%0d]", g), 32'(gnt_id_w[g]), 32'(0));
            check($sformatf("rst_busy[%0d]", g), 32'(busy_w[g]), 32'(0));
            m[g].holder = 0;
            m[g].held   = 0;
            m[g].masked = 0;
        end
        req = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:1] r;
        n_checks = 0;
        n_errors = 0;
        rst = 1'b0;
        req = '0;
        m[0].tenure = 4;
        m[1].tenure = 2;
        m[2].tenure = 1;
        do_reset();
        tick(7'b0000000);

        // Single request, then async reset in the middle of the grant.
        tick(7'b0000100);
        check("single_gnt", 32'(gnt_w[0]), 32'(7'b0000100));
        check("single_id", 32'(gnt_id_w[0]), 32'(3));
        check("single_busy", 32'(busy_w[0]), 32'(1));
        do_reset();

        // Simultaneous requests 2 and 5, then handover.
        for (int i = 0; i < 5; i++) begin
            tick(R34[i]);
            check("handover_id", 32'(gnt_id_w[0]), 32'(E34[i]));
        end
        do_reset();

        // Tenure preemption at TENURE = 4.
        for (int i = 0; i < 8; i++) begin
            tick(R5[i]);
            check("preempt_id", 32'(gnt_id_w[0]), 32'(E5[i]));
        end
        do_reset();

        // TENURE = 2: preemptor releases right after its grant.
        for (int i = 0; i < 6; i++) begin
            tick(R6A[i]);
            check("lone_a_id", 32'(gnt_id_w[1]), 32'(E6A[i]));
        end
        do_reset();

        // TENURE = 2: preemptor withdraws during the turnaround, masked holder is alone.
        for (int i = 0; i < 5; i++) begin
            tick(R6B[i]);
            check("lone_b_id", 32'(gnt_id_w[1]), 32'(E6B[i]));
        end
        do_reset();

        // Random traffic against the reference model.
        r = '0;
        for (int c = 0; c < 3000; c++) begin
            for (int b = 1; b <= 7; b++) begin
                if ($urandom_range(0, 5) == 0) r[b] = ~r[b];
            end
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
            end
            tick(r);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/bus_arbiter7.md
# bus_arbiter7

Shares one 8-bit tri-state bus among seven requesters, one `drive8` output-enable per requester. Fixed-priority arbitration uses the `priority7` encoding, where requester 1 is highest and requester 7 is lowest. A tenure limit preempts a long-holding master while others are waiting. A mandatory one-cycle turnaround between grants ensures no two drivers are ever enabled in the same cycle.

## Interface
- `TENURE`, default 8: maximum GRANT cycles before forced release when another request is pending; legal range 1..255.
- `clk`  input  1  system clock; all state changes on the rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `req`  input  [7:1]  request lines; a requester holds its bit high for its entire bus tenure.
- `gnt`  output  [7:1]  one-hot grant, or all zero; drives the `drive8` enable of each requester directly.
- `gnt_id`  output  [2:0]  index of the granted requester; 0 = no grant (same encoding as `priority7`).
- `busy`  output  1  high whenever state is GRANT.

## Operation
- State machine has three states: IDLE, GRANT and TURN.
- **IDLE:**
  - If `req` after masking is non-zero, go to GRANT.
  - Load `gnt`/`gnt_id` with the lowest-index pending requester.
  - Clear `tcnt`.
- **GRANT:**
  - `tcnt` increments each cycle and saturates at `TENURE`.
  - If the holder's `req` bit is 0, go to TURN and clear `gnt`. This is a normal release, so `mask` is not set.
  - Otherwise, if `tcnt == TENURE-1` and `(req & ~gnt) != 0`, go to TURN, set `mask = gnt` and clear `gnt`. This is a preemption.
  - Otherwise, stay in GRANT.
- **TURN:**
  - Always lasts exactly one cycle, with `gnt` all zero.
  - Then arbitrate as in IDLE: go to GRANT if a request is pending, else go to IDLE.
- **Arbitration input:** `req & ~mask` if that value is non-zero, else `req`. A masked requester that is the only one pending is still granted.
- **Mask clearing:** `mask` clears on any transition into GRANT, or when the masked requester's `req` bit is 0.
- **Register outputs:** `gnt`, `gnt_id` and `busy` are registered, with no combinational path from `req`.
- **Invariant:** `gnt` has at most one bit set, and `gnt_id` always matches `gnt`.

## Timing
- **Reset values:** state = IDLE, `gnt` = 0, `gnt_id` = 0, `busy` = 0, `tcnt` = 0, `mask` = 0.
- **Reset behaviour:** reset takes effect immediately without a clock edge, including in the middle of a grant.
- **Grant latency:** a request sampled in IDLE is granted at the next rising edge, i.e. 1 cycle.
- **Handover:** release sampled at edge N gives `gnt` = 0 during cycle N..N+1. The next grant appears at edge N+1. The bus is dead for exactly one cycle.
- **Preemption timing:** the holder sees exactly `TENURE` GRANT cycles, then a one-cycle TURN.
- **TENURE = 1:** preemption happens after a single cycle whenever another requester is pending.
- **Release and tenure expiry in the same cycle:** treated as a normal release; `mask` is not set.
- **New requests during GRANT:** ignored until the next arbitration. There is no mid-tenure priority preemption.
- **Requester drops `req` before it is granted:** it is simply not granted. No state is retained for it.

## Structure
- **Shared package `arb_pkg`:**
  - state encoding localparams: IDLE=2'b00, GRANT=2'b01, TURN=2'b10;
  - NREQ=7;
  - ID_NONE=3'd0.
- **Arbitration sub-module:** instantiate the existing `priority7` cell on the masked request vector; do not duplicate the encoder. Generate one-hot `gnt` from its output.
- **Counter:** `tcnt` is 8 bits wide.

## Test plan
1. **Async reset:** assert `rst` mid-cycle while `gnt`=7'b0000100 → `gnt`=0, `gnt_id`=0 and `busy`=0 before the next edge.
2. **Single request:** `req`=7'b0000100 from IDLE → at the next edge `gnt`=7'b0000100, `gnt_id`=3, `busy`=1.
3. **Simultaneous requests:** `req` bits 2 and 5 asserted in the same cycle → `gnt_id`=2; bit 5 stays ungranted while 2 holds.
4. **Handover:** requester 2 drops `req` while 5 is pending → exactly one cycle with `gnt`=0, then `gnt_id`=5.
5. **Tenure preemption:** `TENURE`=4, requester 1 holds `req` continuously and requester 6 is pending → `gnt_id`=1 for exactly 4 cycles, one TURN cycle, then `gnt_id`=6 despite requester 1 still requesting. After 6 releases, one TURN cycle, then `gnt_id`=1.
6. **Lone masked requester:** `TENURE`=2, requester 1 is preempted by 3, and 3 releases immediately → requester 1, now alone, is re-granted after TURN. Throughout, check every cycle that `gnt` is one-hot-or-zero.
